// File: rtl/mem_access_ctrl_if.sv
// Execute-side request, memory-bus and response signals of the memory-access stage.
// The master modport is the controller; the slave modport is its environment.
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_funct3;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;

  logic [ADDR_W-1:0] Address;
  logic              MemWrite;
  logic              MemRead;
  logic [DATA_W-1:0] Write_data;
  logic [STRB_W-1:0] Write_strb;
  logic              Mem_Req_Ready;
  logic [DATA_W-1:0] Read_data;
  logic              Read_data_Valid;
  logic              Read_data_Ready;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_offset;
  logic [2:0]        rsp_funct3;
  logic              rsp_err;

  modport master (
    input  req_valid, req_is_store, req_addr, req_funct3, req_wdata, req_wstrb,
    output req_ready,
    output Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ready,
    input  Mem_Req_Ready, Read_data, Read_data_Valid,
    output rsp_valid, rsp_rdata, rsp_offset, rsp_funct3, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_is_store, req_addr, req_funct3, req_wdata, req_wstrb,
    input  req_ready,
    input  Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ready,
    output Mem_Req_Ready, Read_data, Read_data_Valid,
    input  rsp_valid, rsp_rdata, rsp_offset, rsp_funct3, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Multicycle load/store controller: alignment check, bus request and read-data
// handshakes, and a registered response for the load-extraction stage.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic               clk,
  input  logic               resetn,
  mem_access_ctrl_if.master  bus,
  output logic [31:0]        mem_cycle_cnt
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RDW  = 2'd2,
    RSP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              is_store_q, is_store_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              req_ready_q, req_ready_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_read_q, mem_read_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [STRB_W-1:0] write_strb_q, write_strb_d;
  logic              read_data_ready_q, read_data_ready_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic              misaligned_c;

  // Access-width legality from funct3[1:0] and the low address bits.
  always_comb begin
    misaligned_c = 1'b0;
    unique case (bus.req_funct3[1:0])
      2'b00:   misaligned_c = 1'b0;
      2'b01:   misaligned_c = bus.req_addr[0];
      2'b10:   misaligned_c = |bus.req_addr[1:0];
      default: misaligned_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q           <= IDLE;
      addr_q            <= '0;
      funct3_q          <= '0;
      wdata_q           <= '0;
      wstrb_q           <= '0;
      is_store_q        <= 1'b0;
      err_q             <= 1'b0;
      rdata_q           <= '0;
      cnt_q             <= '0;
      req_ready_q       <= 1'b1;
      address_q         <= '0;
      mem_write_q       <= 1'b0;
      mem_read_q        <= 1'b0;
      write_data_q      <= '0;
      write_strb_q      <= '0;
      read_data_ready_q <= 1'b0;
      rsp_valid_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      funct3_q          <= funct3_d;
      wdata_q           <= wdata_d;
      wstrb_q           <= wstrb_d;
      is_store_q        <= is_store_d;
      err_q             <= err_d;
      rdata_q           <= rdata_d;
      cnt_q             <= cnt_d;
      req_ready_q       <= req_ready_d;
      address_q         <= address_d;
      mem_write_q       <= mem_write_d;
      mem_read_q        <= mem_read_d;
      write_data_q      <= write_data_d;
      write_strb_q      <= write_strb_d;
      read_data_ready_q <= read_data_ready_d;
      rsp_valid_q       <= rsp_valid_d;
    end
  end

  // Next state and payload; outputs are registered from the next state so they
  // line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    is_store_d = is_store_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    cnt_d      = (state_q != IDLE) ? cnt_q + CNT_W'(1) : cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d     = bus.req_addr;
          funct3_d   = bus.req_funct3;
          wdata_d    = bus.req_wdata;
          wstrb_d    = bus.req_wstrb;
          is_store_d = bus.req_is_store;
          err_d      = misaligned_c;
          if (bus.req_is_store || misaligned_c) begin
            rdata_d = '0;
          end
          state_d = misaligned_c ? RSP : REQ;
        end
      end
      REQ: begin
        if (bus.Mem_Req_Ready) begin
          state_d = is_store_q ? RSP : RDW;
        end
      end
      RDW: begin
        if (bus.Read_data_Valid) begin
          rdata_d = bus.Read_data;
          state_d = RSP;
        end
      end
      RSP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d       = (state_d == IDLE);
    address_d         = (state_d == REQ) ? {addr_d[ADDR_W-1:2], 2'b00} : '0;
    mem_write_d       = (state_d == REQ) &&  is_store_d;
    mem_read_d        = (state_d == REQ) && !is_store_d;
    write_data_d      = mem_write_d ? wdata_d : '0;
    write_strb_d      = mem_write_d ? wstrb_d : '0;
    read_data_ready_d = (state_d == RDW);
    rsp_valid_d       = (state_d == RSP);
  end

  assign bus.req_ready       = req_ready_q;
  assign bus.Address         = address_q;
  assign bus.MemWrite        = mem_write_q;
  assign bus.MemRead         = mem_read_q;
  assign bus.Write_data      = write_data_q;
  assign bus.Write_strb      = write_strb_q;
  assign bus.Read_data_Ready = read_data_ready_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_rdata       = rdata_q;
  assign bus.rsp_offset      = addr_q[1:0];
  assign bus.rsp_funct3      = funct3_q;
  assign bus.rsp_err         = err_q;
  assign mem_cycle_cnt       = cnt_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// accesses compared against a transaction-level timing/result model.
module tb_mem_access_ctrl;
  logic        clk;
  logic        resetn;
  logic [31:0] mem_cycle_cnt;

  mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (bus_if.master),
    .mem_cycle_cnt (mem_cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  logic [31:0] model_cnt;

  typedef struct {
    logic        is_store;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          stall;
    int          rd_wait;
    int          rsp_bp;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    int          lat;
    int          mr_cnt;
    int          mw_cnt;
    int          rdr_cnt;
    logic [31:0] addr_seen;
    logic [31:0] wdata_seen;
    logic [3:0]  wstrb_seen;
    bit          bus_unstable;
    bit          rsp_unstable;
    bit          busy_ready;
    bit          ready_before;
    bit          ready_after;
    bit          timeout;
    logic [31:0] rdata;
    logic [1:0]  off;
    logic [2:0]  f3;
    logic        err;
    logic [31:0] cnt_end;
  } obs_t;

  typedef struct {
    logic        err;
    logic [31:0] addr_w;
    int          lat;
    int          req_cycles;
    int          rdr_cycles;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] cnt_delta;
  } exp_t;

  // Transaction-level model: legality, cycle counts and result of one access.
  function automatic exp_t model(input txn_t t);
    exp_t e;
    case (t.f3[1:0])
      2'b00:   e.err = 1'b0;
      2'b01:   e.err = t.addr[0];
      2'b10:   e.err = (t.addr[1:0] != 2'b00);
      default: e.err = 1'b1;
    endcase
    e.addr_w     = t.addr & 32'hFFFF_FFFC;
    e.req_cycles = e.err ? 0 : t.stall + 1;
    e.rdr_cycles = (e.err || t.is_store) ? 0 : t.rd_wait + 1;
    e.lat        = 1 + e.req_cycles + e.rdr_cycles;
    e.rdata      = (e.err || t.is_store) ? 32'h0 : t.rdata;
    e.wdata      = (t.is_store && !e.err) ? t.wdata : 32'h0;
    e.wstrb      = (t.is_store && !e.err) ? t.wstrb : 4'h0;
    e.cnt_delta  = 32'(e.req_cycles + e.rdr_cycles + t.rsp_bp + 1);
    return e;
  endfunction

  task automatic idle_inputs();
    bus_if.req_valid       = 1'b0;
    bus_if.req_is_store    = 1'b0;
    bus_if.req_addr        = 32'h0;
    bus_if.req_funct3      = 3'h0;
    bus_if.req_wdata       = 32'h0;
    bus_if.req_wstrb       = 4'h0;
    bus_if.Mem_Req_Ready   = 1'b0;
    bus_if.Read_data       = 32'h0;
    bus_if.Read_data_Valid = 1'b0;
    bus_if.rsp_ready       = 1'b0;
  endtask

  // Drives one access from IDLE to completion and records what the bus showed.
  task automatic run_txn(input txn_t t, output obs_t o);
    int k, req_seen, rdr_seen, rsp_seen;
    bit done, accepted;
    o = '{default: 0};
    req_seen = 0; rdr_seen = 0; rsp_seen = 0; done = 0; accepted = 0; k = 0;
    @(negedge clk);
    o.ready_before         = bus_if.req_ready;
    bus_if.req_valid       = 1'b1;
    bus_if.req_is_store    = t.is_store;
    bus_if.req_addr        = t.addr;
    bus_if.req_funct3      = t.f3;
    bus_if.req_wdata       = t.wdata;
    bus_if.req_wstrb       = t.wstrb;
    bus_if.Mem_Req_Ready   = 1'b0;
    bus_if.Read_data_Valid = 1'b0;
    bus_if.rsp_ready       = 1'b0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
      bus_if.req_valid = 1'b0;
      if (accepted) begin
        o.ready_after = bus_if.req_ready;
        done = 1;
      end else begin
        if (bus_if.req_ready) o.busy_ready = 1;
        if (bus_if.MemRead || bus_if.MemWrite) begin
          req_seen++;
          if (req_seen == 1) begin
            o.addr_seen  = bus_if.Address;
            o.wdata_seen = bus_if.Write_data;
            o.wstrb_seen = bus_if.Write_strb;
          end else if (bus_if.Address !== o.addr_seen || bus_if.Write_data !== o.wdata_seen ||
                       bus_if.Write_strb !== o.wstrb_seen) begin
            o.bus_unstable = 1;
          end
        end
        if (bus_if.MemRead) o.mr_cnt++;
        if (bus_if.MemWrite) o.mw_cnt++;
        if (bus_if.Read_data_Ready) begin rdr_seen++; o.rdr_cnt++; end
        if (bus_if.rsp_valid) begin
          rsp_seen++;
          if (rsp_seen == 1) begin
            o.lat = k; o.rdata = bus_if.rsp_rdata; o.off = bus_if.rsp_offset;
            o.f3 = bus_if.rsp_funct3; o.err = bus_if.rsp_err;
          end else if (bus_if.rsp_rdata !== o.rdata || bus_if.rsp_offset !== o.off ||
                       bus_if.rsp_funct3 !== o.f3 || bus_if.rsp_err !== o.err) begin
            o.rsp_unstable = 1;
          end
        end
        bus_if.Mem_Req_Ready = (bus_if.MemRead || bus_if.MemWrite) ? (req_seen > t.stall)
                                                                   : 1'($urandom_range(0, 1));
        if (bus_if.Read_data_Ready) begin
          bus_if.Read_data_Valid = (rdr_seen > t.rd_wait);
          bus_if.Read_data       = (rdr_seen > t.rd_wait) ? t.rdata : $urandom;
        end else begin
          bus_if.Read_data_Valid = 1'($urandom_range(0, 1));
          bus_if.Read_data       = $urandom;
        end
        if (bus_if.rsp_valid) begin
          bus_if.rsp_ready = (rsp_seen > t.rsp_bp);
          if (rsp_seen > t.rsp_bp) accepted = 1;
        end else begin
          bus_if.rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    end
    o.timeout = !done;
    o.cnt_end = mem_cycle_cnt;
    idle_inputs();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    checks++; if (bus_if.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", bus_if.req_ready); end
    checks++; if ({bus_if.MemRead, bus_if.MemWrite, bus_if.Read_data_Ready, bus_if.rsp_valid, bus_if.rsp_err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {bus_if.MemRead, bus_if.MemWrite, bus_if.Read_data_Ready, bus_if.rsp_valid, bus_if.rsp_err}); end
    checks++; if ({bus_if.Address, bus_if.Write_data, bus_if.rsp_rdata} !== 96'h0) begin
      errors++; $display("FAIL reset_data got %h %h %h exp 0", bus_if.Address, bus_if.Write_data, bus_if.rsp_rdata); end
    checks++; if (mem_cycle_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0", mem_cycle_cnt); end
    resetn = 1'b1;
    model_cnt = 32'h0;
  endtask

  task automatic test_load_zero_wait();
    txn_t t; obs_t o; exp_t e;
    t = '{is_store: 1'b0, addr: 32'h0000_1004, f3: 3'b010, wdata: 32'h0, wstrb: 4'h0,
          stall: 0, rd_wait: 0, rsp_bp: 0, rdata: 32'hDEAD_BEEF};
    e = model(t);
    run_txn(t, o);
    model_cnt += e.cnt_delta;
    checks++; if (o.addr_seen !== 32'h1004) begin errors++; $display("FAIL lw_addr got %h exp 00001004", o.addr_seen); end
    checks++; if (o.mr_cnt != 1 || o.mw_cnt != 0) begin errors++; $display("FAIL lw_memread got %0d/%0d exp 1/0", o.mr_cnt, o.mw_cnt); end
    checks++; if (o.lat != 3) begin errors++; $display("FAIL lw_latency got %0d exp 3", o.lat); end
    checks++; if (o.rdata !== 32'hDEAD_BEEF || o.off !== 2'd0 || o.err !== 1'b0) begin
      errors++; $display("FAIL lw_rsp got %h/%0d/%b exp deadbeef/0/0", o.rdata, o.off, o.err); end
    checks++; if (o.cnt_end !== 32'd3) begin errors++; $display("FAIL lw_cnt got %0d exp 3", o.cnt_end); end
  endtask

  task automatic test_store_stall();
    txn_t t; obs_t o; exp_t e;
    t = '{is_store: 1'b1, addr: 32'h0000_2003, f3: 3'b000, wdata: 32'h5A5A_5A5A, wstrb: 4'b1000,
          stall: 4, rd_wait: 0, rsp_bp: 0, rdata: 32'h0};
    e = model(t);
    run_txn(t, o);
    model_cnt += e.cnt_delta;
    checks++; if (o.addr_seen !== 32'h2000) begin errors++; $display("FAIL sb_addr got %h exp 00002000", o.addr_seen); end
    checks++; if (o.mw_cnt != 5 || o.mr_cnt != 0 || o.bus_unstable) begin
      errors++; $display("FAIL sb_hold got mw=%0d mr=%0d unstable=%0d exp 5/0/0", o.mw_cnt, o.mr_cnt, o.bus_unstable); end
    checks++; if (o.wdata_seen !== 32'h5A5A_5A5A || o.wstrb_seen !== 4'b1000) begin
      errors++; $display("FAIL sb_wdata got %h/%b exp 5a5a5a5a/1000", o.wdata_seen, o.wstrb_seen); end
    checks++; if (o.rdata !== 32'h0 || o.off !== 2'd3 || o.lat != e.lat) begin
      errors++; $display("FAIL sb_rsp got %h/%0d/lat%0d exp 0/3/lat%0d", o.rdata, o.off, o.lat, e.lat); end
    checks++; if (o.cnt_end !== model_cnt) begin errors++; $display("FAIL sb_cnt got %0d exp %0d", o.cnt_end, model_cnt); end
  endtask

  task automatic test_misaligned();
    txn_t t; obs_t o; exp_t e;
    logic [31:0] addrs [3] = '{32'h3001, 32'h3002, 32'h3000};
    logic [2:0]  f3s   [3] = '{3'b001, 3'b010, 3'b011};
    logic        sts   [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      t = '{is_store: sts[i], addr: addrs[i], f3: f3s[i], wdata: 32'hFFFF_FFFF, wstrb: 4'hF,
            stall: 0, rd_wait: 0, rsp_bp: 0, rdata: 32'h1234_5678};
      e = model(t);
      run_txn(t, o);
      model_cnt += e.cnt_delta;
      checks++; if (o.mr_cnt + o.mw_cnt != 0) begin errors++; $display("FAIL err%0d_traffic got %0d exp 0", i, o.mr_cnt + o.mw_cnt); end
      checks++; if (o.err !== 1'b1 || o.lat != 1 || o.rdata !== 32'h0) begin
        errors++; $display("FAIL err%0d_rsp got err=%b lat=%0d rdata=%h exp 1/1/0", i, o.err, o.lat, o.rdata); end
    end
    checks++; if (mem_cycle_cnt !== model_cnt) begin errors++; $display("FAIL err_cnt got %0d exp %0d", mem_cycle_cnt, model_cnt); end
  endtask

  task automatic test_backpressure();
    txn_t t; obs_t o; exp_t e;
    t = '{is_store: 1'b0, addr: 32'h0000_4002, f3: 3'b100, wdata: 32'h0, wstrb: 4'h0,
          stall: 0, rd_wait: 6, rsp_bp: 3, rdata: 32'hCAFE_F00D};
    e = model(t);
    run_txn(t, o);
    model_cnt += e.cnt_delta;
    checks++; if (o.rdr_cnt != 7) begin errors++; $display("FAIL lbu_rdready got %0d exp 7", o.rdr_cnt); end
    checks++; if (o.rsp_unstable) begin errors++; $display("FAIL lbu_rsp_stable got unstable exp stable"); end
    checks++; if (o.busy_ready || !o.ready_after || !o.ready_before) begin
      errors++; $display("FAIL lbu_req_ready got busy=%0d after=%0d before=%0d exp 0/1/1", o.busy_ready, o.ready_after, o.ready_before); end
    checks++; if (o.rdata !== 32'hCAFE_F00D || o.off !== 2'd2 || o.f3 !== 3'b100 || o.lat != 9) begin
      errors++; $display("FAIL lbu_rsp got %h/%0d/%b/lat%0d exp cafef00d/2/100/lat9", o.rdata, o.off, o.f3, o.lat); end
    checks++; if (o.cnt_end !== model_cnt) begin errors++; $display("FAIL lbu_cnt got %0d exp %0d", o.cnt_end, model_cnt); end
  endtask

  task automatic test_reset_mid_rdw();
    txn_t t; obs_t o; exp_t e;
    @(negedge clk);
    bus_if.req_valid = 1'b1; bus_if.req_is_store = 1'b0; bus_if.req_addr = 32'h5008;
    bus_if.req_funct3 = 3'b010; bus_if.Mem_Req_Ready = 1'b1; bus_if.Read_data_Valid = 1'b0;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus_if.Read_data_Ready !== 1'b1) begin errors++; $display("FAIL rst_rdw_entry got %b exp 1", bus_if.Read_data_Ready); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (bus_if.req_ready !== 1'b1 || bus_if.Read_data_Ready !== 1'b0 || bus_if.rsp_valid !== 1'b0 ||
                  bus_if.MemRead !== 1'b0 || bus_if.Address !== 32'h0) begin
      errors++; $display("FAIL rst_async got rdy=%b rdr=%b rv=%b mr=%b a=%h exp 1/0/0/0/0", bus_if.req_ready,
                         bus_if.Read_data_Ready, bus_if.rsp_valid, bus_if.MemRead, bus_if.Address); end
    checks++; if (mem_cycle_cnt !== 32'h0) begin errors++; $display("FAIL rst_async_cnt got %h exp 0", mem_cycle_cnt); end
    @(negedge clk);
    resetn = 1'b1;
    model_cnt = 32'h0;
    bus_if.Read_data_Valid = 1'b1; bus_if.Read_data = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus_if.rsp_valid !== 1'b0 || bus_if.req_ready !== 1'b1) begin
        errors++; $display("FAIL rst_ignore%0d got rv=%b rdy=%b exp 0/1", i, bus_if.rsp_valid, bus_if.req_ready); end
    end
    idle_inputs();
    t = '{is_store: 1'b0, addr: 32'h0000_600C, f3: 3'b010, wdata: 32'h0, wstrb: 4'h0,
          stall: 1, rd_wait: 1, rsp_bp: 0, rdata: 32'h0BAD_CAFE};
    e = model(t);
    run_txn(t, o);
    model_cnt += e.cnt_delta;
    checks++; if (o.rdata !== e.rdata || o.lat != e.lat || o.cnt_end !== model_cnt) begin
      errors++; $display("FAIL rst_next_load got %h/lat%0d/cnt%0d exp %h/lat%0d/cnt%0d", o.rdata, o.lat, o.cnt_end, e.rdata, e.lat, model_cnt); end
  endtask

  task automatic test_cnt_wrap();
    txn_t t; obs_t o; exp_t e;
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.cnt_q;
    @(negedge clk);
    model_cnt = 32'hFFFF_FFFE;
    checks++; if (mem_cycle_cnt !== model_cnt) begin errors++; $display("FAIL wrap_preset got %h exp fffffffe", mem_cycle_cnt); end
    t = '{is_store: 1'b0, addr: 32'h0000_7000, f3: 3'b010, wdata: 32'h0, wstrb: 4'h0,
          stall: 0, rd_wait: 0, rsp_bp: 0, rdata: 32'h0000_0077};
    e = model(t);
    run_txn(t, o);
    model_cnt += e.cnt_delta;
    checks++; if (o.cnt_end !== 32'h0000_0001 || o.cnt_end !== model_cnt) begin
      errors++; $display("FAIL wrap_cnt got %h exp 00000001", o.cnt_end); end
  endtask

  task automatic test_random();
    txn_t t; obs_t o; exp_t e;
    for (int n = 0; n < 40; n++) begin
      t.is_store = 1'($urandom_range(0, 1));
      t.addr     = $urandom;
      t.f3       = t.is_store ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      t.wdata    = $urandom;
      t.wstrb    = 4'($urandom_range(0, 15));
      t.stall    = int'($urandom_range(0, 3));
      t.rd_wait  = int'($urandom_range(0, 3));
      t.rsp_bp   = int'($urandom_range(0, 2));
      t.rdata    = $urandom;
      e = model(t);
      run_txn(t, o);
      model_cnt += e.cnt_delta;
      checks++; if (o.timeout) begin errors++; $display("FAIL rnd%0d_timeout got stuck exp done", n); end
      checks++; if (o.err !== e.err || o.lat != e.lat) begin
        errors++; $display("FAIL rnd%0d_err_lat got %b/%0d exp %b/%0d", n, o.err, o.lat, e.err, e.lat); end
      checks++; if (o.mr_cnt != (t.is_store ? 0 : e.req_cycles) || o.mw_cnt != (t.is_store ? e.req_cycles : 0) ||
                    o.rdr_cnt != e.rdr_cycles) begin
        errors++; $display("FAIL rnd%0d_bus_cycles got mr=%0d mw=%0d rdr=%0d exp req=%0d rdr=%0d", n, o.mr_cnt, o.mw_cnt, o.rdr_cnt, e.req_cycles, e.rdr_cycles); end
      if (!e.err) begin
        checks++; if (o.addr_seen !== e.addr_w || o.wdata_seen !== e.wdata || o.wstrb_seen !== e.wstrb || o.bus_unstable) begin
          errors++; $display("FAIL rnd%0d_bus got %h/%h/%b/u%0d exp %h/%h/%b/u0", n, o.addr_seen, o.wdata_seen, o.wstrb_seen, o.bus_unstable, e.addr_w, e.wdata, e.wstrb); end
      end
      checks++; if (o.rdata !== e.rdata || o.off !== t.addr[1:0] || o.f3 !== t.f3 || o.rsp_unstable) begin
        errors++; $display("FAIL rnd%0d_rsp got %h/%0d/%b/u%0d exp %h/%0d/%b/u0", n, o.rdata, o.off, o.f3, o.rsp_unstable, e.rdata, t.addr[1:0], t.f3); end
      checks++; if (o.busy_ready || !o.ready_after || o.cnt_end !== model_cnt) begin
        errors++; $display("FAIL rnd%0d_ready_cnt got busy=%0d after=%0d cnt=%0d exp 0/1/%0d", n, o.busy_ready, o.ready_after, o.cnt_end, model_cnt); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_cnt = 32'h0;
    test_reset();
    test_load_zero_wait();
    test_store_stall();
    test_misaligned();
    test_backpressure();
    test_reset_mid_rdw();
    test_cnt_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
